// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing one 6-bit signed ALU, with a
// held response stage and a counter of completed response handshakes.
module alu_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [5:0]       req0_a,
    input  logic [5:0]       req0_b,
    input  logic [1:0]       req0_opr,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [5:0]       req1_a,
    input  logic [5:0]       req1_b,
    input  logic [1:0]       req1_opr,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [6:0]       rsp_data,
    output logic             rsp_id,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [5:0]       a_r;
    logic [5:0]       b_r;
    logic [1:0]       opr_r;
    logic             id_r;
    logic             last_grant_r;
    logic [6:0]       rsp_data_r;
    logic             rsp_id_r;
    logic [CNT_W-1:0] op_count_r;
    logic             grant_s;
    logic             accept_s;
    logic [5:0]       alu_res_s;

    // Every intermediate is kept at 6 bits so all arithmetic wraps naturally.
    function automatic logic [5:0] alu_calc(input logic [5:0] a,
                                            input logic [5:0] b,
                                            input logic [1:0] opr);
        logic [5:0] t;
        logic [5:0] res;
        t   = 6'd0;
        res = 6'd0;
        case (opr)
            2'b00: res = {a[3:0], 2'b00} + {b[5], b[5:1]};
            2'b01: res = a + b + {b[4:0], 1'b0};
            2'b10: res = 6'd0 - b;
            2'b11: begin
                t   = {a[4:0], 1'b0} - b;
                res = t[5] ? (6'd0 - t) : t;
            end
            default: res = 6'd0;
        endcase
        return res;
    endfunction

    assign alu_res_s = alu_calc(a_r, b_r, opr_r);

    // Grant selection, readies and next-state decode.
    always_comb begin
        state_s    = state_r;
        grant_s    = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_r)
            IDLE: begin
                if (req0_valid && req1_valid) begin
                    grant_s = ~last_grant_r;
                end else if (req1_valid) begin
                    grant_s = 1'b1;
                end else begin
                    grant_s = 1'b0;
                end
                if (!rst && (req0_valid || req1_valid)) begin
                    req0_ready = ~grant_s;
                    req1_ready = grant_s;
                    state_s    = EXEC;
                end else begin
                    state_s = IDLE;
                end
            end
            EXEC: state_s = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    assign accept_s = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    // State, operand latch, response register and completion counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            a_r          <= 6'd0;
            b_r          <= 6'd0;
            opr_r        <= 2'd0;
            id_r         <= 1'b0;
            last_grant_r <= 1'b1;
            rsp_data_r   <= 7'd0;
            rsp_id_r     <= 1'b0;
            op_count_r   <= '0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                a_r          <= grant_s ? req1_a : req0_a;
                b_r          <= grant_s ? req1_b : req0_b;
                opr_r        <= grant_s ? req1_opr : req0_opr;
                id_r         <= grant_s;
                last_grant_r <= grant_s;
            end
            if (state_r == EXEC) begin
                rsp_data_r <= {alu_res_s[5], alu_res_s};
                rsp_id_r   <= id_r;
            end
            if ((state_r == RESP) && rsp_ready) begin
                op_count_r <= op_count_r + CNT_W'(1);
            end
        end
    end

    assign rsp_valid = (state_r == RESP);
    assign rsp_data  = rsp_data_r;
    assign rsp_id    = rsp_id_r;
    assign op_count  = op_count_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a default-width instance and a CNT_W=2
// instance share all inputs so counter wrap is observed alongside normal use.
module tb_alu_arbiter;

    logic       clk;
    logic       rst;
    logic       req0_valid, req1_valid, rsp_ready;
    logic [5:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0] req0_opr, req1_opr;
    logic       req0_ready, req1_ready, rsp_valid, rsp_id;
    logic [6:0] rsp_data;
    logic [7:0] op_count;
    logic       req0_ready2, req1_ready2, rsp_valid2, rsp_id2;
    logic [6:0] rsp_data2;
    logic [1:0] op_count2;

    int         pass_cnt = 0;
    int         total_cnt = 0;
    int         exp_cnt = 0;

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_opr(req0_opr),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_opr(req1_opr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .op_count(op_count)
    );

    alu_arbiter #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready2),
        .req0_a(req0_a), .req0_b(req0_b), .req0_opr(req0_opr),
        .req1_valid(req1_valid), .req1_ready(req1_ready2),
        .req1_a(req1_a), .req1_b(req1_b), .req1_opr(req1_opr),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data2), .rsp_id(rsp_id2), .op_count(op_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic test_reset();
        rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready});
        else pass_cnt++;
        total_cnt++;
        if ({rsp_valid, rsp_id, rsp_data} !== 9'd0) $display("FAIL reset_rsp: got v=%b id=%b d=%h want 0", rsp_valid, rsp_id, rsp_data);
        else pass_cnt++;
        total_cnt++;
        if (op_count !== 8'd0 || op_count2 !== 2'd0) $display("FAIL reset_count: got %0d/%0d want 0", op_count, op_count2);
        else pass_cnt++;
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        exp_cnt = 0;
    endtask

    // One complete operation from a single requester with rsp_ready high.
    task automatic run_op(input logic id, input logic [5:0] a, input logic [5:0] b,
                          input logic [1:0] opr, input logic [6:0] exp, input string name);
        @(negedge clk);
        rsp_ready = 1'b1;
        if (id == 1'b0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_opr = opr;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_opr = opr;
        end
        #1;
        total_cnt++;
        if ({req1_ready, req0_ready} !== (id ? 2'b10 : 2'b01)) $display("FAIL %s_ready: got %b want %b", name, {req1_ready, req0_ready}, (id ? 2'b10 : 2'b01));
        else pass_cnt++;
        @(posedge clk);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = ~a; req1_a = ~a; req0_b = ~b; req1_b = ~b;
        @(negedge clk);
        total_cnt++;
        if (rsp_valid !== 1'b0) $display("FAIL %s_exec_valid: got %b want 0", name, rsp_valid);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (rsp_valid !== 1'b1 || rsp_id !== id) $display("FAIL %s_rsp: got v=%b id=%b want v=1 id=%b", name, rsp_valid, rsp_id, id);
        else pass_cnt++;
        total_cnt++;
        if (rsp_data !== exp) $display("FAIL %s_data: got %h want %h", name, rsp_data, exp);
        else pass_cnt++;
        exp_cnt++;
        @(negedge clk);
        total_cnt++;
        if (rsp_valid !== 1'b0 || op_count !== 8'(exp_cnt) || op_count2 !== 2'(exp_cnt))
            $display("FAIL %s_done: got v=%b cnt=%0d cnt2=%0d want v=0 cnt=%0d cnt2=%0d",
                     name, rsp_valid, op_count, op_count2, 8'(exp_cnt), 2'(exp_cnt));
        else pass_cnt++;
    endtask

    task automatic test_single();
        run_op(1'b0, 6'd3, 6'd4, 2'b00, 7'd14, "single");
    endtask

    task automatic test_sweep();
        run_op(1'b0, 6'd3, 6'd4, 2'b01, 7'd15, "opr01");
        run_op(1'b1, 6'd3, 6'd4, 2'b10, 7'h7C, "opr10");
        run_op(1'b0, 6'd3, 6'd4, 2'b11, 7'd2, "opr11");
        run_op(1'b1, 6'h30, 6'd0, 2'b11, 7'h60, "opr11_wrap");
    endtask

    task automatic test_round_robin();
        logic exp_id;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; exp_cnt = 0; rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 6'd3; req0_b = 6'd4;  req0_opr = 2'b01;
        req1_valid = 1'b1; req1_a = 6'd5; req1_b = 6'h3E; req1_opr = 2'b00;
        for (int k = 0; k < 4; k++) begin
            exp_id = k[0];
            #1;
            total_cnt++;
            if ({req1_ready, req0_ready} !== {exp_id, ~exp_id}) $display("FAIL rr_ready%0d: got %b want %b", k, {req1_ready, req0_ready}, {exp_id, ~exp_id});
            else pass_cnt++;
            @(negedge clk);
            @(negedge clk);
            total_cnt++;
            if (rsp_valid !== 1'b1 || rsp_id !== exp_id) $display("FAIL rr_id%0d: got v=%b id=%b want v=1 id=%b", k, rsp_valid, rsp_id, exp_id);
            else pass_cnt++;
            total_cnt++;
            if (rsp_data !== (exp_id ? 7'h13 : 7'd15)) $display("FAIL rr_data%0d: got %h want %h", k, rsp_data, (exp_id ? 7'h13 : 7'd15));
            else pass_cnt++;
            exp_cnt++;
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        total_cnt++;
        if (op_count !== 8'd4) $display("FAIL rr_count: got %0d want 4", op_count);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        req1_valid = 1'b1; req1_a = 6'd1; req1_b = 6'd1; req1_opr = 2'b10; rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        req1_valid = 1'b0; req0_valid = 1'b1; req1_b = 6'd9;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total_cnt++;
            if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 7'h7F)
                $display("FAIL bp_hold%0d: got v=%b id=%b d=%h want v=1 id=1 d=7f", i, rsp_valid, rsp_id, rsp_data);
            else pass_cnt++;
            total_cnt++;
            if ({req0_ready, req1_ready} !== 2'b00 || op_count !== 8'(exp_cnt))
                $display("FAIL bp_idle%0d: got rdy=%b cnt=%0d want rdy=00 cnt=%0d", i, {req0_ready, req1_ready}, op_count, 8'(exp_cnt));
            else pass_cnt++;
        end
        rsp_ready = 1'b1;
        #1;
        total_cnt++;
        if (req0_ready !== 1'b0) $display("FAIL bp_no_accept: got %b want 0", req0_ready);
        else pass_cnt++;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        exp_cnt++;
        @(negedge clk);
        total_cnt++;
        if (rsp_valid !== 1'b0 || op_count !== 8'(exp_cnt)) $display("FAIL bp_done: got v=%b cnt=%0d want v=0 cnt=%0d", rsp_valid, op_count, 8'(exp_cnt));
        else pass_cnt++;
    endtask

    task automatic test_reset_exec();
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 6'd3; req0_b = 6'd4; req0_opr = 2'b00; rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({req0_ready, req1_ready, rsp_valid} !== 3'b000) $display("FAIL rx_in_reset: got %b want 000", {req0_ready, req1_ready, rsp_valid});
        else pass_cnt++;
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; exp_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total_cnt++;
            if (rsp_valid !== 1'b0 || op_count !== 8'd0 || op_count2 !== 2'd0)
                $display("FAIL rx_quiet%0d: got v=%b cnt=%0d cnt2=%0d want 0", i, rsp_valid, op_count, op_count2);
            else pass_cnt++;
        end
        req0_valid = 1'b1; req0_a = 6'd2; req0_b = 6'd1; req0_opr = 2'b01;
        req1_valid = 1'b1; req1_a = 6'd7; req1_b = 6'd7; req1_opr = 2'b10;
        #1;
        total_cnt++;
        if ({req1_ready, req0_ready} !== 2'b01) $display("FAIL rx_tie: got %b want 01", {req1_ready, req0_ready});
        else pass_cnt++;
        @(posedge clk);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total_cnt++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 7'd5)
            $display("FAIL rx_tie_rsp: got v=%b id=%b d=%h want v=1 id=0 d=05", rsp_valid, rsp_id, rsp_data);
        else pass_cnt++;
        exp_cnt++;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        exp_cnt = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            run_op(i[0], 6'(i), 6'd1, 2'b01, 7'(i + 3), "wrap");
        end
        total_cnt++;
        if (op_count2 !== 2'd1 || op_count !== 8'd5) $display("FAIL wrap_final: got %0d/%0d want 1/5", op_count2, op_count);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_a = 6'd0; req0_b = 6'd0; req0_opr = 2'd0;
        req1_valid = 1'b0; req1_a = 6'd0; req1_b = 6'd0; req1_opr = 2'd0;
        test_reset();
        test_single();
        test_sweep();
        test_round_robin();
        test_backpressure();
        test_reset_exec();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
